// File: rtl/prog_loader_if.sv
// Bus bundle between the UART program loader and its host: RX byte stream, CPU RAM write port,
// arbitrated RAM port and loader status.
interface prog_loader_if;
  logic       load_req;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cpu_ram_we;
  logic [3:0] cpu_ram_addr;
  logic [7:0] cpu_ram_wdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output load_req, rx_valid, rx_data, cpu_ram_we, cpu_ram_addr, cpu_ram_wdata,
    input  ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, error
  );

  modport slave (
    input  load_req, rx_valid, rx_data, cpu_ram_we, cpu_ram_addr, cpu_ram_wdata,
    output ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a 16-byte program into RAM from a UART byte stream framed by a header byte and closed by
// an 8-bit additive checksum; owns the RAM write port and holds the CPU while loading.
module prog_loader #(
  parameter int unsigned TIMEOUT = 1200000,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input logic          clk,
  input logic          clr,
  prog_loader_if.slave bus
);

  localparam int unsigned    TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWaitHdr, StData, StCsum, StErr} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            we_q, we_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    error_d = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load_req) state_d = StWaitHdr;
      end
      StWaitHdr: begin
        if (bus.rx_valid && (bus.rx_data == HEADER)) begin
          state_d = StData;
          cnt_d   = 4'd0;
          csum_d  = 8'd0;
          tmo_d   = '0;
        end
      end
      StData: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (bus.rx_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = bus.rx_data;
          csum_d  = csum_q + bus.rx_data;
          cnt_d   = cnt_q + 4'd1;
          tmo_d   = '0;
          if (cnt_q == 4'd15) state_d = StCsum;
        end else if (tmo_q == TmoLast) begin
          error_d = 1'b1;
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCsum: begin
        if (bus.rx_valid) begin
          tmo_d = '0;
          if (bus.rx_data == csum_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            error_d = 1'b1;
            state_d = StErr;
          end
        end else if (tmo_q == TmoLast) begin
          error_d = 1'b1;
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StErr: begin
        if (bus.load_req) begin
          error_d = 1'b0;
          state_d = StWaitHdr;
        end
      end
      default: state_d = StIdle;
    endcase

    // Hold is released one cycle after the done pulse so the CPU restarts on a settled RAM.
    hold_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      csum_q  <= 8'd0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 4'd0;
      wdata_q <= 8'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.cpu_hold = hold_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

  always_comb begin
    if (state_q == StIdle) begin
      bus.ram_we    = bus.cpu_ram_we;
      bus.ram_addr  = bus.cpu_ram_addr;
      bus.ram_wdata = bus.cpu_ram_wdata;
    end else begin
      bus.ram_we    = we_q;
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected RAM writes are queued as bytes are sent and
// compared against the arbitrated RAM port whenever the loader owns it.
module tb_prog_loader;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(
    .TIMEOUT(100),
    .HEADER (8'hA5)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [11:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit wr, input logic [3:0] a);
    if (wr) sb.push_back({a, b});
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step,
                            output logic [7:0] sum);
    logic [7:0] b;
    sum = 8'd0;
    for (int i = 0; i < 16; i++) begin
      b   = base + 8'(i) * step;
      sum = sum + b;
      send(b, 1'b1, 4'(i));
    end
  endtask

  // Loader-owned writes must match the scoreboard in order; any extra write is an error.
  always @(negedge clk) begin
    if (bus.busy && bus.ram_we) begin
      if (sb.size() == 0) begin
        check("unexp_we", 32'(bus.ram_we), 32'd0);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(e[11:8]));
        check("wr_data", 32'(bus.ram_wdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    logic [7:0] sum;
    clr               = 1'b1;
    bus.load_req      = 1'b0;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'd0;
    bus.cpu_ram_we    = 1'b0;
    bus.cpu_ram_addr  = 4'd0;
    bus.cpu_ram_wdata = 8'd0;
    tick(2);
    clr = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hold", 32'(bus.cpu_hold), 32'd0);
    check("rst_err", 32'(bus.error), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // CPU owns the port in IDLE; bytes are ignored there.
    bus.cpu_ram_we    = 1'b1;
    bus.cpu_ram_addr  = 4'd7;
    bus.cpu_ram_wdata = 8'h3C;
    #1;
    check("arb_idle_we", 32'(bus.ram_we), 32'd1);
    check("arb_idle_addr", 32'(bus.ram_addr), 32'd7);
    check("arb_idle_data", 32'(bus.ram_wdata), 32'h3C);
    send(8'hA5, 1'b0, 4'd0);
    check("idle_rx_ignored", 32'(bus.busy), 32'd0);

    // Good load; CPU write strobe stays high during DATA and must be ignored.
    pulse_load();
    check("load_busy", 32'(bus.busy), 32'd1);
    check("load_hold", 32'(bus.cpu_hold), 32'd1);
    send(8'hA5, 1'b0, 4'd0);
    tick();
    check("arb_data_we", 32'(bus.ram_we), 32'd0);
    bus.cpu_ram_addr = 4'd9;
    send_frame(8'h00, 8'h01, sum);
    bus.cpu_ram_we = 1'b0;
    send(8'h78, 1'b0, 4'd0);
    check("good_done", 32'(bus.done), 32'd1);
    check("good_hold", 32'(bus.cpu_hold), 32'd1);
    check("good_err", 32'(bus.error), 32'd0);
    tick();
    check("good_done_fall", 32'(bus.done), 32'd0);
    check("good_hold_fall", 32'(bus.cpu_hold), 32'd0);

    // Bad checksum.
    pulse_load();
    send(8'hA5, 1'b0, 4'd0);
    send_frame(8'h00, 8'h01, sum);
    send(8'h77, 1'b0, 4'd0);
    check("bad_err", 32'(bus.error), 32'd1);
    check("bad_busy", 32'(bus.busy), 32'd1);
    check("bad_hold", 32'(bus.cpu_hold), 32'd1);
    check("bad_done", 32'(bus.done), 32'd0);
    send(8'h55, 1'b0, 4'd0);
    check("err_sticky", 32'(bus.error), 32'd1);
    pulse_load();
    check("err_clr", 32'(bus.error), 32'd0);
    check("err_reload_busy", 32'(bus.busy), 32'd1);

    // Header filter, then a load with a different pattern.
    send(8'h00, 1'b0, 4'd0);
    send(8'hFF, 1'b0, 4'd0);
    check("hdr_wait", 32'(bus.busy), 32'd1);
    send(8'hA5, 1'b0, 4'd0);
    send_frame(8'h10, 8'h03, sum);
    send(sum, 1'b0, 4'd0);
    check("hdr_done", 32'(bus.done), 32'd1);
    tick();

    // Timeout: error exactly 100 cycles after the last byte; load_req ignored in DATA.
    pulse_load();
    send(8'hA5, 1'b0, 4'd0);
    send(8'h11, 1'b1, 4'd0);
    send(8'h22, 1'b1, 4'd1);
    send(8'h33, 1'b1, 4'd2);
    tick(49);
    pulse_load();
    tick(49);
    check("tmo_early", 32'(bus.error), 32'd0);
    tick();
    check("tmo_err", 32'(bus.error), 32'd1);
    check("tmo_busy", 32'(bus.busy), 32'd1);
    check("tmo_hold", 32'(bus.cpu_hold), 32'd1);
    tick(5);
    pulse_load();

    // Reset mid-load, then a fresh load starting at address 0.
    send(8'hA5, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b1, 4'(i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_hold", 32'(bus.cpu_hold), 32'd0);
    check("clr_err", 32'(bus.error), 32'd0);
    pulse_load();
    send(8'hA5, 1'b0, 4'd0);
    send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), sum);
    send(sum, 1'b0, 4'd0);
    check("rand_done", 32'(bus.done), 32'd1);
    tick(3);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
